// File: rtl/mole_scheduler.sv
`timescale 1ns/1ps
// Whac-A-Mole in-play sequencer: prescaled game tick, spawn timer, per-hole lifetimes, hit/expiry retirement.
// Optional build macro WHIFF_PENALTY_EN: a click on an empty hole while running also counts as a miss.
module mole_scheduler #(
    parameter int NUM_MOLES  = 12,
    parameter int CLK_DIV    = 100000,
    parameter int SPAWN_BASE = 1000,
    parameter int SPAWN_STEP = 80,
    parameter int SPAWN_MIN  = 200,
    parameter int LIFE_BASE  = 1500,
    parameter int LIFE_STEP  = 100,
    parameter int MAX_ACTIVE = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 clear,
    input  logic [3:0]           level,
    input  logic [3:0]           rand_val,
    input  logic [NUM_MOLES-1:0] hit,
    output logic [NUM_MOLES-1:0] mole_up,
    output logic                 score_pulse,
    output logic                 miss_pulse,
    output logic [3:0]           miss_cnt,
    output logic [3:0]           active_cnt
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    function automatic logic [3:0] clamp_level(input logic [3:0] lv);
        if (lv == 4'd0) return 4'd1;
        if (lv > 4'd10) return 4'd10;
        return lv;
    endfunction

    // base - step*(lv-1), floored; the floor test runs before the subtraction so it never wraps
    function automatic logic [11:0] floor_sub(input logic [11:0] base, input logic [11:0] step,
                                             input logic [11:0] floor_v, input logic [3:0] lv);
        logic [11:0] dec;
        dec = step * {8'd0, lv - 4'd1};
        if (base <= floor_v || dec >= base - floor_v) return floor_v;
        return base - dec;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic inc);
        if (inc && v != 4'hF) return v + 4'd1;
        return v;
    endfunction

    function automatic logic [3:0] popcount(input logic [NUM_MOLES-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NUM_MOLES; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

    function automatic logic [3:0] pick_hole(input logic [NUM_MOLES-1:0] up, input logic [3:0] cand);
        logic [3:0] pick;
        logic       found;
        logic [4:0] j;
        pick  = cand;
        found = 1'b0;
        for (int k = 0; k < NUM_MOLES; k++) begin
            j = {1'b0, cand} + 5'(k);
            if (j >= 5'(NUM_MOLES)) j = j - 5'(NUM_MOLES);
            if (!found && !up[j[3:0]]) begin
                pick  = j[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    logic [PW-1:0]        presc;
    logic [11:0]          spawn_timer;
    logic                 pending;
    logic [11:0]          life [NUM_MOLES];
    logic [3:0]           lvl, cand, spawn_hole, miss_next;
    logic [11:0]          interval, lifetime;
    logic                 tick, fire, spawn_go, whiff;
    logic [NUM_MOLES-1:0] hit_live, hit_sel, expire, spawn_mask, up_next;

    assign lvl      = clamp_level(level);
    assign interval = floor_sub(12'(SPAWN_BASE), 12'(SPAWN_STEP), 12'(SPAWN_MIN), lvl);
    assign lifetime = floor_sub(12'(LIFE_BASE), 12'(LIFE_STEP), 12'(SPAWN_MIN), lvl);
    assign tick     = run && (presc == PW'(CLK_DIV - 1));
    assign fire     = tick && (spawn_timer == 12'd1);

    // x & -x isolates the lowest-index hit on a raised mole
    assign hit_live = run ? (hit & mole_up) : '0;
    assign hit_sel  = hit_live & (~hit_live + NUM_MOLES'(1));

    always_comb begin
        expire = '0;
        for (int i = 0; i < NUM_MOLES; i++)
            expire[i] = tick && mole_up[i] && !hit_sel[i] && (life[i] <= 12'd1);
    end

    assign cand       = (rand_val < 4'(NUM_MOLES)) ? rand_val : rand_val - 4'(NUM_MOLES);
    assign spawn_go   = run && pending && (active_cnt < 4'(MAX_ACTIVE));
    assign spawn_hole = pick_hole(mole_up, cand);
    assign spawn_mask = spawn_go ? (NUM_MOLES'(1) << spawn_hole) : '0;
    assign up_next    = (mole_up & ~hit_sel & ~expire) | spawn_mask;

`ifdef WHIFF_PENALTY_EN
    assign whiff = run && (|(hit & ~mole_up));
`else
    assign whiff = 1'b0;
`endif

    assign miss_next = sat_inc(popcount(expire), whiff);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc       <= '0;
            spawn_timer <= '0;
            pending     <= 1'b0;
            mole_up     <= '0;
            active_cnt  <= '0;
            score_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            miss_cnt    <= '0;
            for (int i = 0; i < NUM_MOLES; i++) life[i] <= '0;
        end else if (clear) begin
            presc       <= '0;
            spawn_timer <= interval;
            pending     <= 1'b0;
            mole_up     <= '0;
            active_cnt  <= '0;
            score_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            miss_cnt    <= '0;
            for (int i = 0; i < NUM_MOLES; i++) life[i] <= '0;
        end else begin
            if (run) presc <= tick ? '0 : presc + PW'(1);
            // A zero timer only follows async reset: load it from the level seen now
            if (spawn_timer == 12'd0)
                spawn_timer <= interval;
            else if (tick)
                spawn_timer <= (spawn_timer == 12'd1) ? interval : spawn_timer - 12'd1;
            pending     <= (pending && !spawn_go) || fire;
            mole_up     <= up_next;
            active_cnt  <= popcount(up_next);
            score_pulse <= |hit_sel;
            miss_pulse  <= (miss_next != 4'd0);
            miss_cnt    <= miss_next;
            for (int i = 0; i < NUM_MOLES; i++) begin
                if (spawn_mask[i])
                    life[i] <= lifetime;
                else if (hit_sel[i] || expire[i])
                    life[i] <= '0;
                else if (tick && mole_up[i])
                    life[i] <= life[i] - 12'd1;
            end
        end
    end
endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Sequences the in-play phase of Whac-A-Mole: decides when and where moles pop up, ages each raised mole, and retires it on a hit or a timeout.
- Sits under the game top-level FSM, which gates it with `run` and `clear`.
- Consumes the mouse monitor's per-hole click vector and the random generator output.
- Drives the `mole_up` bitmap, plus score and miss pulses back to the game FSM.

Parameters:
- NUM_MOLES, 12: number of holes (fixed at 12; `mole_up` width).
- CLK_DIV, 100000: clk cycles per game tick (1 ms at 100 MHz).
- SPAWN_BASE, 1000: spawn interval in ticks at level 1.
- SPAWN_STEP, 80: interval reduction per level above 1.
- SPAWN_MIN, 200: interval floor.
- LIFE_BASE, 1500: mole lifetime in ticks at level 1.
- LIFE_STEP, 100: lifetime reduction per level above 1.
- MAX_ACTIVE, 3: maximum simultaneously raised moles.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- run, in, 1: game running (started, not paused, not won/lost).
- clear, in, 1: synchronous restart pulse.
- level, in, 4: game level.
- rand_val, in, 4: random value from the random generator.
- hit, in, 12: one-cycle click-on-hole pulses, bit i = hole i.
- mole_up, out, 12: raised-mole bitmap.
- score_pulse, out, 1: one-cycle pulse, a raised mole was hit.
- miss_pulse, out, 1: one-cycle pulse, at least one mole expired.
- miss_cnt, out, 4: number of moles expired this cycle; valid with `miss_pulse`, else 0.
- active_cnt, out, 4: popcount of `mole_up`.

Behaviour:
- Reset (async) and `clear` (sync, highest synchronous priority):
  - `mole_up`, both pulses, `miss_cnt`, prescaler, all life counters and the pending flag go to 0.
  - Spawn timer loads the interval for the current level.
- Level clamp: `level` 0 is treated as 1; `level` > 10 is treated as 10.
- Spawn interval = max(SPAWN_MIN, SPAWN_BASE − SPAWN_STEP·(L−1)).
- Lifetime = max(SPAWN_MIN, LIFE_BASE − LIFE_STEP·(L−1)).
- All interval and lifetime arithmetic is 12-bit unsigned, clamped before any subtraction can underflow.
- `run` = 0 (pause) freezes everything: prescaler, spawn timer, life counters and `mole_up` hold; `hit` is ignored; pulses stay 0.
- Prescaler:
  - Counts 0..CLK_DIV−1 while `run` = 1.
  - `tick` is asserted in the cycle the count wraps.
- Spawn timer:
  - Decrements on `tick`.
  - On reaching 0 it sets `pending` and reloads the interval.
- Spawn:
  - Executes in a cycle with `pending` = 1 and `active_cnt` < MAX_ACTIVE.
  - Candidate = `rand_val` if `rand_val` < 12, else `rand_val` − 12.
  - If the candidate hole is already up, take the first free hole searching upward circularly from the candidate.
  - Set that `mole_up` bit, load its life counter with the lifetime, clear `pending`.
  - While `active_cnt` = MAX_ACTIVE, `pending` holds; spawn timer keeps running; a second expiry while pending is dropped (`pending` stays 1).
- Aging: on `tick`, each raised mole's life counter decrements; a mole whose counter reaches 0 is cleared that cycle.
- Expiry output: all expirations in a cycle are counted in `miss_cnt`; `miss_pulse` = (`miss_cnt` ≠ 0).
- Hit:
  - When `run` = 1, the lowest index i with `hit[i]` & `mole_up[i]` clears mole i and asserts `score_pulse` the next cycle.
  - Other simultaneous hits are ignored.
- Simultaneous events:
  - Hit and expiry on the same mole in the same cycle count as a hit (no miss for it).
  - Spawn selection uses the pre-update `mole_up`, so a hole being cleared this cycle is not reused until the next cycle.
- Latency: all outputs are registered; an effect appears the cycle after its cause.
- `active_cnt` is registered popcount of `mole_up`, updated with it.

Optional Feature:
- Macro: WHIFF_PENALTY_EN.
- Defined: a `hit` on a hole that is not up (with `run` = 1) counts as a miss. It adds 1 to `miss_cnt` (saturating at 15) and asserts `miss_pulse` in the same output cycle as any expiries.
- Undefined: such clicks are ignored.

Test Plan (CLK_DIV=4, SPAWN_BASE=10, SPAWN_STEP=2, SPAWN_MIN=4, LIFE_BASE=8, LIFE_STEP=1, MAX_ACTIVE=3):
- Spawn then expire: `run`=1, `level`=1, `rand_val`=5 → `mole_up` = 0x020 after 10 ticks (40 clk). The mole ages 8 ticks, then `mole_up` = 0; `miss_pulse`=1 and `miss_cnt`=1 for one cycle.
- Hit: mole 5 up, `hit`=0x020 → next cycle `mole_up`=0, `score_pulse`=1 for one cycle, no miss.
- Remap and collision: `rand_val`=14 with hole 2 already up → hole 3 raised.
- MAX_ACTIVE limit: with 3 moles up, the spawn interval elapses → no new mole. Hit one → the pending spawn occurs the following cycle.
- Pause: `run`=0 for 100 cycles mid-life → `mole_up` unchanged and expiry delayed by exactly 100 cycles. `hit` during pause has no effect.
- `clear` and async `reset` mid-game with 2 moles up → all outputs 0 immediately. The first spawn comes a full interval later; `level`=7 gives an interval of max(4, 10−12) = 4 ticks.
